// File: rtl/accumulator_mc.sv
`default_nettype none
// ============================================================================
// Module      : accumulator_mc
// Description : CHANNELS independent running sums fed by a valid/ready stream
//               with per-word add/subtract, sticky per-channel overflow flags,
//               a registered read port and a one-channel-per-cycle clear sweep.
//               Optional macro ACC_SATURATE_EN: clamp on overflow instead of wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module accumulator_mc #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 16,
    parameter int CHANNELS = 4,
    localparam int CH_W    = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_W-1:0]     in_ch,
    input  logic                in_sub,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                clr,
    output logic                busy,
    input  logic                rd_req,
    input  logic [CH_W-1:0]     rd_ch,
    output logic                rd_valid,
    output logic [ACC_W-1:0]    rd_data,
    output logic                rd_ovf,
    output logic [CHANNELS-1:0] ovf_flags
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [CH_W-1:0] c_LAST_IDX = CH_W'(CHANNELS - 1);

    state_t              r_state;
    logic [CH_W-1:0]     r_idx;
    logic [ACC_W-1:0]    r_acc [CHANNELS];
    logic [CHANNELS-1:0] r_ovf;

    logic                w_accept;
    logic [ACC_W-1:0]    w_cur;
    logic [ACC_W-1:0]    w_rd_acc;
    logic                w_rd_flag;
    logic [ACC_W:0]      w_addend;
    logic [ACC_W:0]      w_sum;
    logic                w_over;
    logic [ACC_W-1:0]    w_next;

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_CLEAR);
    assign w_accept  = in_valid & in_ready;
    assign ovf_flags = r_ovf;

    // Channel selects that match no accumulator (out-of-range index) yield zero.
    always_comb begin
        w_cur     = '0;
        w_rd_acc  = '0;
        w_rd_flag = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_ch == CH_W'(i)) begin
                w_cur = r_acc[i];
            end
            if (rd_ch == CH_W'(i)) begin
                w_rd_acc  = r_acc[i];
                w_rd_flag = r_ovf[i];
            end
        end
    end

    // One extra bit catches the carry on add and the borrow on subtract.
    assign w_addend = {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
    assign w_sum    = in_sub ? ({1'b0, w_cur} - w_addend) : ({1'b0, w_cur} + w_addend);
    assign w_over   = w_sum[ACC_W];

`ifdef ACC_SATURATE_EN
    assign w_next = w_over ? (in_sub ? {ACC_W{1'b0}} : {ACC_W{1'b1}}) : w_sum[ACC_W-1:0];
`else
    assign w_next = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr) begin
                        r_state <= ST_CLEAR;
                        r_idx   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    // No word is accepted while sweeping, so clear and update never collide.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if ((r_state == ST_CLEAR) && (r_idx == CH_W'(i))) begin
                    r_acc[i] <= '0;
                    r_ovf[i] <= 1'b0;
                end else if (w_accept && (in_ch == CH_W'(i))) begin
                    r_acc[i] <= w_next;
                    if (w_over) begin
                        r_ovf[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_ovf   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= w_rd_acc;
                rd_ovf  <= w_rd_flag;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accumulator_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_accumulator_mc
// Description : Directed and randomized stimulus for accumulator_mc, checked
//               cycle by cycle against an integer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accumulator_mc;

    localparam int DATA_W   = 8;
    localparam int ACC_W    = 16;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 2;
    localparam int ACC_MAX  = (1 << ACC_W) - 1;

    logic                clk = 1'b0;
    logic                n_rst;
    logic                in_valid;
    logic                in_ready;
    logic [CH_W-1:0]     in_ch;
    logic                in_sub;
    logic [DATA_W-1:0]   in_data;
    logic                clr;
    logic                busy;
    logic                rd_req;
    logic [CH_W-1:0]     rd_ch;
    logic                rd_valid;
    logic [ACC_W-1:0]    rd_data;
    logic                rd_ovf;
    logic [CHANNELS-1:0] ovf_flags;

    accumulator_mc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CHANNELS(CHANNELS)) dut (
        .clk(clk), .n_rst(n_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_sub(in_sub), .in_data(in_data),
        .clr(clr), .busy(busy),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_valid(rd_valid), .rd_data(rd_data), .rd_ovf(rd_ovf),
        .ovf_flags(ovf_flags)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain integers, sweep tracked as "channels left to clear".
    int   m_acc [CHANNELS];
    bit   m_ovf [CHANNELS];
    int   m_clr_left;
    int   e_rd_data;
    bit   e_rd_ovf;
    bit   e_rd_valid;
    int   busy_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_flags();
        logic [31:0] f = '0;
        for (int i = 0; i < CHANNELS; i++) f[i] = m_ovf[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CHANNELS; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
        end
        m_clr_left = 0;
        e_rd_data  = 0;
        e_rd_ovf   = 1'b0;
        e_rd_valid = 1'b0;
    endtask

    task automatic model_word(input int ch, input bit sub, input int d);
        int s;
        if (ch >= CHANNELS) return;
        s = sub ? m_acc[ch] - d : m_acc[ch] + d;
        if (s < 0 || s > ACC_MAX) begin
            m_ovf[ch] = 1'b1;
`ifdef ACC_SATURATE_EN
            s = (s < 0) ? 0 : ACC_MAX;
`else
            s = (s < 0) ? s + ACC_MAX + 1 : s - ACC_MAX - 1;
`endif
        end
        m_acc[ch] = s;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, (m_clr_left == 0)});
        check({tag, ".busy"},      {31'd0, busy},      {31'd0, (m_clr_left != 0)});
        check({tag, ".rd_valid"},  {31'd0, rd_valid},  {31'd0, e_rd_valid});
        check({tag, ".rd_data"},   {16'd0, rd_data},   e_rd_data);
        check({tag, ".rd_ovf"},    {31'd0, rd_ovf},    {31'd0, e_rd_ovf});
        check({tag, ".ovf_flags"}, {28'd0, ovf_flags}, model_flags());
    endtask

    // One clock edge: the model consumes the inputs present at the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        e_rd_valid = rd_req;
        if (rd_req) begin
            e_rd_data = (int'(rd_ch) < CHANNELS) ? m_acc[rd_ch] : 0;
            e_rd_ovf  = (int'(rd_ch) < CHANNELS) ? m_ovf[rd_ch] : 1'b0;
        end
        if (m_clr_left > 0) begin
            m_acc[CHANNELS - m_clr_left] = 0;
            m_ovf[CHANNELS - m_clr_left] = 1'b0;
            m_clr_left--;
        end else begin
            if (in_valid) model_word(int'(in_ch), in_sub, int'(in_data));
            if (clr) m_clr_left = CHANNELS;
        end
        #1;
        if (busy) busy_seen++;
        check_all(tag);
    endtask

    task automatic drive_in(input bit v, input int ch, input bit sub, input int d);
        in_valid = v;
        in_ch    = CH_W'(ch);
        in_sub   = sub;
        in_data  = DATA_W'(d);
    endtask

    task automatic drive_rd(input bit req, input int ch);
        rd_req = req;
        rd_ch  = CH_W'(ch);
    endtask

    initial begin
        // Reset values, checked before any clock edge has been seen by the DUT.
        n_rst = 1'b0;
        clr   = 1'b0;
        drive_in(0, 0, 0, 0);
        drive_rd(0, 0);
        model_reset();
        #2;
        check_all("reset");
        #10;
        n_rst = 1'b1;

        // Back-to-back adds on channel 1, then read every channel.
        drive_in(1, 1, 0, 'h10); tick("add1");
        drive_in(1, 1, 0, 'h20); tick("add2");
        drive_in(1, 1, 0, 'h30); tick("add3");
        drive_in(0, 0, 0, 0);
        drive_rd(1, 1); tick("rd_ch1");
        check("add.rd_ch1_value", {16'd0, rd_data}, 32'h60);
        drive_rd(1, 0); tick("rd_ch0");
        drive_rd(1, 2); tick("rd_ch2");
        drive_rd(1, 3); tick("rd_ch3");
        drive_rd(0, 0); tick("rd_idle");

        // Build ch2 = 0xFFF0, then overflow it with +0x20.
        for (int k = 0; k < 256; k++) begin
            drive_in(1, 2, 0, 'hFF);
            tick("load2");
        end
        drive_in(1, 2, 0, 'hF0); tick("load2_last");
        drive_in(1, 2, 0, 'h20); tick("ovf_add");
        drive_in(1, 3, 1, 'h05); drive_rd(1, 2); tick("ovf_sub");
`ifdef ACC_SATURATE_EN
        check("ovf.add_value", {16'd0, rd_data}, 32'hFFFF);
`else
        check("ovf.add_value", {16'd0, rd_data}, 32'h0010);
`endif
        drive_in(0, 0, 0, 0); drive_rd(1, 3); tick("rd_sub");
`ifdef ACC_SATURATE_EN
        check("ovf.sub_value", {16'd0, rd_data}, 32'h0000);
`else
        check("ovf.sub_value", {16'd0, rd_data}, 32'hFFFB);
`endif
        check("ovf.flags23", {30'd0, ovf_flags[3:2]}, 32'h3);

        // Read/update collision: read returns the pre-update value.
        drive_rd(0, 0);
        drive_in(1, 0, 0, 'h03); tick("coll_load");
        drive_in(1, 0, 0, 'h07); drive_rd(1, 0); tick("coll_same");
        check("coll.same_cycle", {16'd0, rd_data}, 32'h3);
        drive_in(0, 0, 0, 0); tick("coll_next");
        check("coll.next_cycle", {16'd0, rd_data}, 32'hA);

        // Clear with a same-cycle accepted word, in_valid held, second clr mid-sweep.
        drive_rd(0, 0);
        busy_seen = 0;
        clr = 1'b1;
        drive_in(1, 1, 0, 'h11); tick("clr_start");
        clr = 1'b0; tick("clr_sweep1");
        clr = 1'b1; tick("clr_sweep2");
        clr = 1'b0; tick("clr_sweep3");
        tick("clr_sweep4");
        check("clr.busy_cycles", busy_seen, 32'd4);
        drive_in(0, 0, 0, 0);
        for (int c = 0; c < CHANNELS; c++) begin
            drive_rd(1, c);
            tick("clr_readback");
            check("clr.read_zero", {16'd0, rd_data}, 32'h0);
        end
        check("clr.flags_zero", {28'd0, ovf_flags}, 32'h0);
        drive_rd(0, 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 500; k++) begin
            drive_in($urandom_range(0, 3) != 0, $urandom_range(0, CHANNELS - 1),
                     $urandom_range(0, 2) == 0, $urandom_range(0, 255));
            clr = ($urandom_range(0, 39) == 0);
            drive_rd($urandom_range(0, 1) == 1, $urandom_range(0, CHANNELS - 1));
            tick("rand");
        end

        // Asynchronous reset in the middle of a sweep with traffic pending.
        clr = 1'b1;
        drive_in(1, 2, 0, 'h40);
        drive_rd(1, 2);
        tick("pre_rst_clr");
        clr = 1'b0;
        tick("pre_rst_sweep");
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_all("midsweep_reset");
        @(negedge clk);
        n_rst = 1'b1;
        drive_in(0, 0, 0, 0);
        drive_rd(1, 2);
        tick("post_rst_read");
        drive_rd(0, 0);
        tick("post_rst_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
